// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : 640x480@60 timing constants, derived totals and sync windows,
//            colour field widths and a 10-bit window-compare helper.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

   // Default pixel divider: 100 MHz system clock -> 25 MHz pixel rate
   localparam int C_CLK_DIV  = 4;

   // Horizontal timing in pixels
   localparam int C_H_VIS    = 640;
   localparam int C_H_FP     = 16;
   localparam int C_H_SYNC   = 96;
   localparam int C_H_BP     = 48;

   // Vertical timing in lines
   localparam int C_V_VIS    = 480;
   localparam int C_V_FP     = 10;
   localparam int C_V_SYNC   = 2;
   localparam int C_V_BP     = 33;

   // Derived totals and sync windows (start inclusive, end exclusive)
   localparam int C_H_TOTAL  = C_H_VIS + C_H_FP + C_H_SYNC + C_H_BP;
   localparam int C_V_TOTAL  = C_V_VIS + C_V_FP + C_V_SYNC + C_V_BP;
   localparam int C_HS_START = C_H_VIS + C_H_FP;
   localparam int C_HS_END   = C_HS_START + C_H_SYNC;
   localparam int C_VS_START = C_V_VIS + C_V_FP;
   localparam int C_VS_END   = C_VS_START + C_V_SYNC;

   // Counter width; 799 and 524 both fit in 10 bits
   localparam int C_CNT_W    = 10;

   // Colour field widths (RGB 3:3:2)
   localparam int C_RED_W    = 3;
   localparam int C_GREEN_W  = 3;
   localparam int C_BLUE_W   = 2;
   localparam int C_RGB_W    = C_RED_W + C_GREEN_W + C_BLUE_W;

   typedef logic [C_CNT_W-1:0] cnt_t;

   typedef struct packed {
      logic [C_RED_W-1:0]   r;
      logic [C_GREEN_W-1:0] g;
      logic [C_BLUE_W-1:0]  b;
   } rgb_t;

   // True when lo <= v < hi, compared at counter width
   function automatic logic in_window(cnt_t v, int lo, int hi);
      return (v >= cnt_t'(lo)) && (v < cnt_t'(hi));
   endfunction

endpackage : vga_pkg
`default_nettype wire

// File: rtl/clk_enable_div.sv
`default_nettype none
// ============================================================================
// Module   : clk_enable_div
// Purpose  : Divides clk into a one-clock enable pulse every DIV clocks.
//            tick_o is the combinational "pulse on next edge" term so that a
//            consumer can update state on the same edge that raises pix_en_o.
// Revision : 1.0 - initial release
// ============================================================================
module clk_enable_div #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick_o,
   output logic pix_en_o
);

   logic pix_en_q;

   generate
      if (DIV == 1) begin : g_div1
         // Every edge is a pixel edge; pix_en goes high on the first edge and stays
         assign tick_o = 1'b1;

         // Registered enable held high continuously out of reset
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               pix_en_q <= 1'b0;
            end else begin
               pix_en_q <= 1'b1;
            end
         end
      end else begin : g_divn
         localparam int C_CW = $clog2(DIV);

         logic [C_CW-1:0] cnt_q;
         logic [C_CW-1:0] cnt_d;

         // Terminal count: the coming edge raises pix_en and restarts the count
         assign tick_o = (cnt_q == C_CW'(DIV - 1));

         // Next count wraps to zero at terminal count
         always_comb begin
            cnt_d = tick_o ? '0 : (cnt_q + C_CW'(1));
         end

         // Divider counter and registered enable pulse
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_q    <= '0;
               pix_en_q <= 1'b0;
            end else begin
               cnt_q    <= cnt_d;
               pix_en_q <= tick_o;
            end
         end
      end
   endgenerate

   assign pix_en_o = pix_en_q;

endmodule : clk_enable_div
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing
// Purpose  : VGA pixel-timing source. Runs the horizontal/vertical counters
//            on the pixel enable, exposes them as xpos/ypos, samples the
//            game's colour for that position and drives blanked, sync-aligned
//            pins one pixel later, plus line/frame strobes.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing
   import vga_pkg::*;
#(
   parameter int CLK_DIV = C_CLK_DIV,
   parameter int H_VIS   = C_H_VIS,
   parameter int H_FP    = C_H_FP,
   parameter int H_SYNC  = C_H_SYNC,
   parameter int H_BP    = C_H_BP,
   parameter int V_VIS   = C_V_VIS,
   parameter int V_FP    = C_V_FP,
   parameter int V_SYNC  = C_V_SYNC,
   parameter int V_BP    = C_V_BP
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [C_RED_W-1:0]   red_in,
   input  logic [C_GREEN_W-1:0] green_in,
   input  logic [C_BLUE_W-1:0]  blue_in,
   output logic [C_CNT_W-1:0]   xpos,
   output logic [C_CNT_W-1:0]   ypos,
   output logic                 pix_en,
   output logic                 line_tick,
   output logic                 frame_tick,
   output logic                 hsync,
   output logic                 vsync,
   output logic [C_RED_W-1:0]   vga_red,
   output logic [C_GREEN_W-1:0] vga_green,
   output logic [C_BLUE_W-1:0]  vga_blue
);

   localparam int C_HT       = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int C_VT       = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int C_HS_LO    = H_VIS + H_FP;
   localparam int C_HS_HI    = C_HS_LO + H_SYNC;
   localparam int C_VS_LO    = V_VIS + V_FP;
   localparam int C_VS_HI    = C_VS_LO + V_SYNC;

   // Pixel enable; w_tick marks the edge on which pix_en rises
   logic w_tick;
   logic w_pix_en;

   clk_enable_div #(
      .DIV (CLK_DIV)
   ) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick_o   (w_tick),
      .pix_en_o (w_pix_en)
   );

   cnt_t xpos_q, xpos_d;
   cnt_t ypos_q, ypos_d;
   logic line_tick_q, frame_tick_q;
   logic hsync_q, vsync_q;
   rgb_t rgb_q;

   logic w_x_last, w_y_last;
   logic w_line_d, w_frame_d;
   logic w_hsync_raw, w_vsync_raw, w_visible;
   rgb_t w_rgb_d;

   // Next counter values and strobe conditions for the coming pixel edge
   always_comb begin
      w_x_last  = (xpos_q == cnt_t'(C_HT - 1));
      w_y_last  = (ypos_q == cnt_t'(C_VT - 1));
      xpos_d    = w_x_last ? '0 : (xpos_q + cnt_t'(1));
      ypos_d    = ypos_q;
      if (w_x_last) begin
         ypos_d = w_y_last ? '0 : (ypos_q + cnt_t'(1));
      end
      w_line_d  = w_x_last;
      w_frame_d = w_x_last && (ypos_d == cnt_t'(V_VIS));
   end

   // Sync and blanking decode of the pixel currently presented to the game
   always_comb begin
      w_hsync_raw = !in_window(xpos_q, C_HS_LO, C_HS_HI);
      w_vsync_raw = !in_window(ypos_q, C_VS_LO, C_VS_HI);
      w_visible   = (xpos_q < cnt_t'(H_VIS)) && (ypos_q < cnt_t'(V_VIS));
      w_rgb_d     = w_visible ? rgb_t'({red_in, green_in, blue_in}) : '0;
   end

   // Horizontal/vertical counters, advanced only on pixel edges
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xpos_q <= '0;
         ypos_q <= '0;
      end else if (w_tick) begin
         xpos_q <= xpos_d;
         ypos_q <= ypos_d;
      end
   end

   // One-clock strobes, raised together with pix_en
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_tick_q  <= 1'b0;
         frame_tick_q <= 1'b0;
      end else begin
         line_tick_q  <= w_tick && w_line_d;
         frame_tick_q <= w_tick && w_frame_d;
      end
   end

   // Output pins: sync and blanked colour of the pixel just finished
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         rgb_q   <= '0;
      end else if (w_tick) begin
         hsync_q <= w_hsync_raw;
         vsync_q <= w_vsync_raw;
         rgb_q   <= w_rgb_d;
      end
   end

   assign xpos       = xpos_q;
   assign ypos       = ypos_q;
   assign pix_en     = w_pix_en;
   assign line_tick  = line_tick_q;
   assign frame_tick = frame_tick_q;
   assign hsync      = hsync_q;
   assign vsync      = vsync_q;
   assign vga_red    = rgb_q.r;
   assign vga_green  = rgb_q.g;
   assign vga_blue   = rgb_q.b;

endmodule : vga_timing
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing
// Purpose  : Scoreboard bench for vga_timing. Instance 0 uses the default
//            640x480 timing with CLK_DIV=4; instance 1 uses a shrunken
//            32x17 raster with CLK_DIV=1 so whole frames fit in the run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       lt;
      logic       ft;
      logic       hs;
      logic       vs;
      logic [7:0] rgb;
   } exp_t;

   typedef struct packed {
      int div;
      int hvis; int hfp; int hsync; int hbp;
      int vvis; int vfp; int vsync; int vbp;
   } tim_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [2:0] red_i   [2];
   logic [2:0] green_i [2];
   logic [1:0] blue_i  [2];
   logic [9:0] xpos_o  [2];
   logic [9:0] ypos_o  [2];
   logic       pe_o    [2];
   logic       lt_o    [2];
   logic       ft_o    [2];
   logic       hs_o    [2];
   logic       vs_o    [2];
   logic [2:0] vr_o    [2];
   logic [2:0] vg_o    [2];
   logic [1:0] vb_o    [2];

   vga_timing u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .red_in(red_i[0]), .green_in(green_i[0]), .blue_in(blue_i[0]),
      .xpos(xpos_o[0]), .ypos(ypos_o[0]), .pix_en(pe_o[0]),
      .line_tick(lt_o[0]), .frame_tick(ft_o[0]),
      .hsync(hs_o[0]), .vsync(vs_o[0]),
      .vga_red(vr_o[0]), .vga_green(vg_o[0]), .vga_blue(vb_o[0])
   );

   vga_timing #(
      .CLK_DIV(1), .H_VIS(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
      .V_VIS(10), .V_FP(2), .V_SYNC(2), .V_BP(3)
   ) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .red_in(red_i[1]), .green_in(green_i[1]), .blue_in(blue_i[1]),
      .xpos(xpos_o[1]), .ypos(ypos_o[1]), .pix_en(pe_o[1]),
      .line_tick(lt_o[1]), .frame_tick(ft_o[1]),
      .hsync(hs_o[1]), .vsync(vs_o[1]),
      .vga_red(vr_o[1]), .vga_green(vg_o[1]), .vga_blue(vb_o[1])
   );

   exp_t q0[$];
   exp_t q1[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   last_pe [2];
   int   n_tick  [2];
   exp_t last_exp[2];
   logic primed = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic tim_t tim(int i);
      tim_t t;
      if (i == 0) t = '{4, 640, 16, 96, 48, 480, 10, 2, 33};
      else        t = '{1, 20, 3, 5, 4, 10, 2, 2, 3};
      return t;
   endfunction

   // Expected DUT state on the n-th pixel edge after reset release.
   // The counters sit at pixel n; the pins show pixel n-1 with colour c.
   function automatic exp_t model(int i, int n, logic [7:0] c);
      tim_t t  = tim(i);
      int   ht = t.hvis + t.hfp + t.hsync + t.hbp;
      int   vt = t.vvis + t.vfp + t.vsync + t.vbp;
      int   x  = n % ht;
      int   y  = (n / ht) % vt;
      int   px = (n - 1) % ht;
      int   py = ((n - 1) / ht) % vt;
      exp_t e;
      e.x   = 10'(x);
      e.y   = 10'(y);
      e.lt  = (x == 0);
      e.ft  = (x == 0) && (y == t.vvis);
      e.hs  = !((px >= t.hvis + t.hfp) && (px < t.hvis + t.hfp + t.hsync));
      e.vs  = !((py >= t.vvis + t.vfp) && (py < t.vvis + t.vfp + t.vsync));
      e.rgb = ((px < t.hvis) && (py < t.vvis)) ? c : 8'h00;
      return e;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive a new colour for the pixel period that starts now and queue the
   // response expected on the pixel edge that ends it
   task automatic drive_push(int i);
      logic [7:0] c;
      c = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      red_i[i]   = c[7:5];
      green_i[i] = c[4:2];
      blue_i[i]  = c[1:0];
      n_tick[i]  = n_tick[i] + 1;
      if (i == 0) q0.push_back(model(i, n_tick[i], c));
      else        q1.push_back(model(i, n_tick[i], c));
   endtask

   task automatic mon(int i);
      tim_t t = tim(i);
      exp_t e;
      logic got;
      if (pe_o[i]) begin
         got = 1'b0;
         if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
         if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
         check($sformatf("u%0d.sb_nonempty", i), got, 1);
         if (got) begin
            check($sformatf("u%0d.xpos", i), xpos_o[i], e.x);
            check($sformatf("u%0d.ypos", i), ypos_o[i], e.y);
            check($sformatf("u%0d.line_tick", i), lt_o[i], e.lt);
            check($sformatf("u%0d.frame_tick", i), ft_o[i], e.ft);
            check($sformatf("u%0d.hsync", i), hs_o[i], e.hs);
            check($sformatf("u%0d.vsync", i), vs_o[i], e.vs);
            check($sformatf("u%0d.rgb", i), {vr_o[i], vg_o[i], vb_o[i]}, e.rgb);
            last_exp[i] = e;
         end
         check($sformatf("u%0d.pix_gap", i), cyc - last_pe[i], t.div);
         last_pe[i] = cyc;
      end else begin
         check($sformatf("u%0d.strobe_idle", i), {lt_o[i], ft_o[i]}, 0);
         check($sformatf("u%0d.xpos_hold", i), xpos_o[i], last_exp[i].x);
         check($sformatf("u%0d.gap_bound", i), (cyc - last_pe[i]) < t.div, 1);
      end
   endtask

   // Stimulus: new colour at the start of every pixel period
   always @(negedge clk) begin
      if (primed) begin
         for (int i = 0; i < 2; i++) begin
            if (pe_o[i]) drive_push(i);
         end
      end
   end

   // Monitor: compare against the scoreboard whenever a pixel edge is seen
   always @(negedge clk) begin
      if (primed) begin
         for (int i = 0; i < 2; i++) mon(i);
      end
   end

   task automatic check_reset(string tag);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s.u%0d.xpos", tag, i), xpos_o[i], 0);
         check($sformatf("%s.u%0d.ypos", tag, i), ypos_o[i], 0);
         check($sformatf("%s.u%0d.hsync", tag, i), hs_o[i], 1);
         check($sformatf("%s.u%0d.vsync", tag, i), vs_o[i], 1);
         check($sformatf("%s.u%0d.rgb", tag, i), {vr_o[i], vg_o[i], vb_o[i]}, 0);
         check($sformatf("%s.u%0d.strobes", tag, i), {pe_o[i], lt_o[i], ft_o[i]}, 0);
      end
   endtask

   // Called on a negedge while rst_n is low: seed the scoreboard, then release
   task automatic prime_release();
      for (int i = 0; i < 2; i++) begin
         n_tick[i]   = 0;
         last_exp[i] = '0;
         last_pe[i]  = cyc;
      end
      q0.delete();
      q1.delete();
      for (int i = 0; i < 2; i++) drive_push(i);
      rst_n  = 1'b1;
      primed = 1'b1;
   endtask

   initial begin
      bit found;
      for (int i = 0; i < 2; i++) begin
         red_i[i] = 3'd7; green_i[i] = 3'd7; blue_i[i] = 2'd3;
      end
      rst_n = 1'b0;
      repeat (10) @(negedge clk);
      check_reset("reset");

      prime_release();
      repeat (20000) @(negedge clk);

      // Asynchronous reset in the middle of an hsync pulse
      found = 1'b0;
      for (int k = 0; k < 4000 && !found; k++) begin
         @(negedge clk);
         if (xpos_o[0] == 10'd700 && hs_o[0] == 1'b0) found = 1'b1;
      end
      check("find_x700_hsync_low", found, 1);
      primed = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_reset("async");

      repeat (5) @(negedge clk);
      check_reset("held");
      prime_release();
      repeat (3000) @(negedge clk);
      primed = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_vga_timing
`default_nettype wire
